mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single four-banked main memory (16-bit address/data, per-bank m_busy[3:0]) between the instruction-cache controller (port I) and the data-cache controller (port D).
- Grants whole transactions (evict and/or 4-word fill bursts), not single beats.
- Routes read data back to the port that issued the read, using an owner-tag pipeline matched to memory read latency.
- Sits between the two cache FSMs and the memory model.

Parameters:
- RD_LAT, 2, cycles from m_rd issue to valid m_data_out
- MAX_HOLD, 64, cycles a port may own memory while the other port waits, before a forced handover request

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- i_req  in  1  I port requests ownership; held for the whole transaction
- i_addr  in  16  I port memory address
- i_data_in  in  16  I port write data
- i_wr  in  1  I port write strobe
- i_rd  in  1  I port read strobe
- d_req, d_addr, d_data_in, d_wr, d_rd  in  1/16/16/1/1  D port, same meaning as I port
- m_data_out  in  16  memory read data
- m_busy  in  4  memory per-bank busy
- m_err  in  1  memory error
- i_gnt  out  1  I port owns memory
- d_gnt  out  1  D port owns memory
- i_data_out  out  16  routed read data for I
- d_data_out  out  16  routed read data for D
- i_busy  out  4  bank busy seen by I
- d_busy  out  4  bank busy seen by D
- i_err  out  1  I port error pulse
- d_err  out  1  D port error pulse
- i_yield  out  1  request for I to finish its transaction
- d_yield  out  1  request for D to finish its transaction
- m_addr  out  16  memory address
- m_data_in  out  16  memory write data
- m_wr  out  1  memory write
- m_rd  out  1  memory read

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; i_gnt=d_gnt=0; last_owner=D, so I wins the first tie; hold counter=0; tag pipeline cleared.
  - All outputs are 0 except i_busy=d_busy=4'b1111.
- State machine, registered:
  - IDLE: only d_req → OWN_D. Otherwise any i_req → OWN_I when i_req is alone or last_owner=D. Both requesting → the port ≠ last_owner. Gnt rises the cycle after the req is sampled.
  - OWN_x: x_gnt=1. The mux drives m_addr/m_data_in/m_wr/m_rd from port x combinationally. On x_req=0 → DRAIN and last_owner<=x.
  - DRAIN: no gnt; m_wr=m_rd=0. Exit when m_busy==0 and the tag pipeline is empty. Exit goes directly to the next grant using the IDLE rules, else to IDLE. Minimum one DRAIN cycle.
- Non-owner view: x_busy=4'b1111 and x_data_out=0. Owner x_busy=m_busy.
- Command rules:
  - Non-owner strobes are ignored.
  - Owner with wr&rd both high in the same cycle: no memory command issued; x_err pulses for 1 cycle; ownership retained.
  - m_err is forwarded to the current owner's err, else dropped.
- Read return:
  - Each cycle the arbiter shifts a (valid, owner) tag into an RD_LAT-deep pipeline. The tag is valid when m_rd=1.
  - At the pipeline tail, a valid tag routes m_data_out to that owner's data_out; otherwise data_out=0.
  - Routing is independent of current gnt, so in-flight reads complete across DRAIN.
- Fairness:
  - The hold counter increments each cycle in OWN_x while the other req=1, and clears on leaving OWN_x.
  - At MAX_HOLD, x_yield=1 until x_req drops. The arbiter never revokes gnt itself.
- Reset mid-transaction: all state and pipelines are cleared immediately; in-flight read data is discarded (no data_out).
- Simultaneous req drop by the owner and raise by the other: normal DRAIN, then grant.

Test Plan:
1. I-only request: i_req=1 at cycle 0 → i_gnt=1 from cycle 1. i_rd with i_addr=16'h0040 drives m_rd=1, m_addr=16'h0040. m_data_out=16'hBEEF two cycles later → i_data_out=16'hBEEF, d_data_out=0.
2. Tie after reset: i_req=d_req=1 → I granted first. I drops req → DRAIN until m_busy=0 → d_gnt=1. A second tie after D finishes → I granted (round robin).
3. Drain across owner change:
   - I issues reads to banks 0–3.
   - i_req drops the cycle after the last rd.
   - d_gnt is held 0 while m_busy≠0.
   - All four read words appear on i_data_out, none on d_data_out.
4. Illegal strobe: owner D drives d_wr=d_rd=1 → m_wr=m_rd=0 that cycle; d_err=1 for one cycle; d_gnt stays 1.
5. Starvation: D holds ownership with i_req=1 for 64 cycles → d_yield=1 at cycle 64. d_req drops → i_gnt after DRAIN; d_yield=0.
6. Async reset mid-burst: rst=0 with a read in flight → all gnt=0 and m_rd=0 immediately; no data_out pulse after release; i_busy=d_busy=4'b1111.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Transaction-level arbiter sharing one banked memory between I and D caches.
// Ports: clk, rst (async active-low); per-port req/addr/data_in/wr/rd in,
//   gnt/data_out/busy/err/yield out; memory m_* command out, data/busy/err in.
module mem_port_arbiter #(
    parameter int RD_LAT   = 2,
    parameter int MAX_HOLD = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_data_in,
    input  logic        i_wr,
    input  logic        i_rd,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    input  logic        d_wr,
    input  logic        d_rd,
    input  logic [15:0] m_data_out,
    input  logic [3:0]  m_busy,
    input  logic        m_err,
    output logic        i_gnt,
    output logic        d_gnt,
    output logic [15:0] i_data_out,
    output logic [15:0] d_data_out,
    output logic [3:0]  i_busy,
    output logic [3:0]  d_busy,
    output logic        i_err,
    output logic        d_err,
    output logic        i_yield,
    output logic        d_yield,
    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    output logic        m_wr,
    output logic        m_rd
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, OWN_I, OWN_D, DRAIN} state_e;

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [RD_LAT-1:0] tv_q, tv_d;
    logic [RD_LAT-1:0] to_q, to_d;

    logic        own_i, own_d;
    logic        pick_i, pick_d;
    logic        o_wr, o_rd, bad;
    logic [15:0] o_addr, o_din;
    logic        tail_v, tail_d;

    assign own_i = (state_q == OWN_I);
    assign own_d = (state_q == OWN_D);

    // I wins unless D alone, or a tie where I owned last
    assign pick_i = i_req & (~d_req | last_d_q);
    assign pick_d = d_req & ~pick_i;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        hold_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_i)      state_d = OWN_I;
                else if (pick_d) state_d = OWN_D;
            end
            OWN_I: begin
                if (!i_req) begin
                    state_d  = DRAIN;
                    last_d_d = 1'b0;
                end else if (d_req && hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    hold_d = hold_q;
                end
            end
            OWN_D: begin
                if (!d_req) begin
                    state_d  = DRAIN;
                    last_d_d = 1'b1;
                end else if (i_req && hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    hold_d = hold_q;
                end
            end
            DRAIN: begin
                // wait out bank activity and any read still returning
                if (m_busy == 4'b0000 && tv_q == '0) begin
                    if (pick_i)      state_d = OWN_I;
                    else if (pick_d) state_d = OWN_D;
                    else             state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_wr   = 1'b0;
        o_rd   = 1'b0;
        o_addr = '0;
        o_din  = '0;
        if (own_i) begin
            o_wr   = i_wr;
            o_rd   = i_rd;
            o_addr = i_addr;
            o_din  = i_data_in;
        end else if (own_d) begin
            o_wr   = d_wr;
            o_rd   = d_rd;
            o_addr = d_addr;
            o_din  = d_data_in;
        end
    end

    // simultaneous wr and rd is illegal: suppress and flag
    assign bad       = o_wr & o_rd;
    assign m_wr      = o_wr & ~bad;
    assign m_rd      = o_rd & ~bad;
    assign m_addr    = o_addr;
    assign m_data_in = o_din;

    assign i_gnt   = own_i;
    assign d_gnt   = own_d;
    assign i_err   = own_i & (bad | m_err);
    assign d_err   = own_d & (bad | m_err);
    assign i_busy  = own_i ? m_busy : 4'b1111;
    assign d_busy  = own_d ? m_busy : 4'b1111;
    assign i_yield = own_i & i_req & (hold_q == HOLD_MAX);
    assign d_yield = own_d & d_req & (hold_q == HOLD_MAX);

    // owner tag pipeline: to=1 marks a D read
    always_comb begin
        tv_d    = '0;
        to_d    = '0;
        tv_d[0] = m_rd;
        to_d[0] = own_d;
        for (int k = 1; k < RD_LAT; k++) begin
            tv_d[k] = tv_q[k-1];
            to_d[k] = to_q[k-1];
        end
    end

    assign tail_v     = tv_q[RD_LAT-1];
    assign tail_d     = to_q[RD_LAT-1];
    assign i_data_out = (tail_v && !tail_d) ? m_data_out : 16'h0000;
    assign d_data_out = (tail_v &&  tail_d) ? m_data_out : 16'h0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            hold_q   <= '0;
            tv_q     <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            hold_q   <= hold_d;
            tv_q     <= tv_d;
            to_q     <= to_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference
// model compared on every clock, plus hand-computed spot expectations.
module tb_mem_port_arbiter;

    localparam int RD_LAT   = 2;
    localparam int MAX_HOLD = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, i_rd, d_req, d_wr, d_rd, m_err;
    logic [15:0] i_addr, i_data_in, d_addr, d_data_in, m_data_out;
    logic [3:0]  m_busy;
    logic        i_gnt, d_gnt, i_err, d_err, i_yield, d_yield, m_wr, m_rd;
    logic [15:0] i_data_out, d_data_out, m_addr, m_data_in;
    logic [3:0]  i_busy, d_busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data_in(i_data_in),
        .i_wr(i_wr), .i_rd(i_rd),
        .d_req(d_req), .d_addr(d_addr), .d_data_in(d_data_in),
        .d_wr(d_wr), .d_rd(d_rd),
        .m_data_out(m_data_out), .m_busy(m_busy), .m_err(m_err),
        .i_gnt(i_gnt), .d_gnt(d_gnt),
        .i_data_out(i_data_out), .d_data_out(d_data_out),
        .i_busy(i_busy), .d_busy(d_busy),
        .i_err(i_err), .d_err(d_err),
        .i_yield(i_yield), .d_yield(d_yield),
        .m_addr(m_addr), .m_data_in(m_data_in),
        .m_wr(m_wr), .m_rd(m_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 none, 1 I, 2 D
    int mo;
    bit mdrain;
    int mlast;
    int mwait;
    int cyc = 0;
    int due_q[$];
    int rown_q[$];

    function automatic int pick(input logic ir, input logic dr, input int lst);
        if (ir && (!dr || lst == 2)) return 1;
        if (dr) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mo = 0; mdrain = 0; mlast = 2; mwait = 0;
            due_q.delete(); rown_q.delete();
        end else begin
            bit pend;
            logic xr, orq, xw, xrd;
            pend = 0;
            foreach (due_q[k]) if (due_q[k] >= cyc) pend = 1;
            if (mo != 0) begin
                xr  = (mo == 1) ? i_req : d_req;
                orq = (mo == 1) ? d_req : i_req;
                xw  = (mo == 1) ? i_wr  : d_wr;
                xrd = (mo == 1) ? i_rd  : d_rd;
                if (xrd && !xw) begin
                    due_q.push_back(cyc + RD_LAT);
                    rown_q.push_back(mo);
                end
                if (!xr) begin
                    mlast = mo; mo = 0; mdrain = 1; mwait = 0;
                end else if (orq) begin
                    mwait++;
                end
            end else if (mdrain) begin
                if (m_busy == 4'b0000 && !pend) begin
                    mdrain = 0;
                    mo = pick(i_req, d_req, mlast);
                end
            end else begin
                mo = pick(i_req, d_req, mlast);
            end
            while (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                void'(rown_q.pop_front());
            end
            cyc++;
        end
    end

    logic        e_wr, e_rd, e_bad;
    logic [15:0] e_a, e_di, e_id, e_dd;

    always @(negedge clk) begin
        if (rst) begin
            e_wr = 0; e_rd = 0; e_a = 0; e_di = 0; e_id = 0; e_dd = 0;
            if (mo == 1) begin
                e_wr = i_wr; e_rd = i_rd; e_a = i_addr; e_di = i_data_in;
            end else if (mo == 2) begin
                e_wr = d_wr; e_rd = d_rd; e_a = d_addr; e_di = d_data_in;
            end
            e_bad = e_wr & e_rd;
            foreach (due_q[k]) begin
                if (due_q[k] == cyc) begin
                    if (rown_q[k] == 1) e_id = m_data_out;
                    else                e_dd = m_data_out;
                end
            end
            chk("i_gnt", i_gnt, mo == 1);
            chk("d_gnt", d_gnt, mo == 2);
            chk("m_wr", m_wr, e_wr & ~e_bad);
            chk("m_rd", m_rd, e_rd & ~e_bad);
            chk("m_addr", m_addr, e_a);
            chk("m_data_in", m_data_in, e_di);
            chk("i_err", i_err, (mo == 1) && (e_bad || m_err));
            chk("d_err", d_err, (mo == 2) && (e_bad || m_err));
            chk("i_busy", i_busy, (mo == 1) ? m_busy : 4'hF);
            chk("d_busy", d_busy, (mo == 2) ? m_busy : 4'hF);
            chk("i_data_out", i_data_out, e_id);
            chk("d_data_out", d_data_out, e_dd);
            chk("i_yield", i_yield, (mo == 1) && i_req && mwait >= MAX_HOLD);
            chk("d_yield", d_yield, (mo == 2) && d_req && mwait >= MAX_HOLD);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit want_d, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (((want_d ? d_gnt : i_gnt) !== 1'b1) && n < 50) begin
            step();
            @(negedge clk);
            n++;
        end
        chk(nm, want_d ? d_gnt : i_gnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        i_req = 0; i_wr = 0; i_rd = 0; i_addr = 0; i_data_in = 0;
        d_req = 0; d_wr = 0; d_rd = 0; d_addr = 0; d_data_in = 0;
        m_data_out = 0; m_busy = 0; m_err = 0;
        repeat (2) step();
        @(negedge clk);
        chk("rst_i_busy", i_busy, 4'hF);
        chk("rst_d_busy", d_busy, 4'hF);
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_m_rd", m_rd, 0);
        step(); rst = 1;

        // 1: I-only read
        step(); i_req = 1;
        @(negedge clk); chk("t1_gnt_c0", i_gnt, 0);
        step();
        @(negedge clk); chk("t1_gnt_c1", i_gnt, 1);
        step(); i_rd = 1; i_addr = 16'h0040;
        @(negedge clk);
        chk("t1_m_rd", m_rd, 1);
        chk("t1_m_addr", m_addr, 16'h0040);
        step(); i_rd = 0;
        step(); m_data_out = 16'hBEEF;
        @(negedge clk);
        chk("t1_i_data", i_data_out, 16'hBEEF);
        chk("t1_d_data", d_data_out, 16'h0000);
        step(); m_data_out = 0; i_req = 0;
        repeat (4) step();

        // 2: tie after reset, then round robin
        rst = 0; step(); rst = 1;
        step(); i_req = 1; d_req = 1;
        wait_gnt(0, "t2_i_first");
        chk("t2_d_wait", d_gnt, 0);
        step(); i_req = 0; m_busy = 4'b0010;
        repeat (3) begin
            step();
            @(negedge clk); chk("t2_drain_hold", d_gnt, 0);
        end
        step(); m_busy = 0;
        wait_gnt(1, "t2_d_next");
        step(); d_req = 0;
        step(); i_req = 1; d_req = 1;
        wait_gnt(0, "t2_rr_i");
        chk("t2_rr_d", d_gnt, 0);
        step(); i_req = 0; d_req = 0;
        repeat (3) step();

        // 3: drain across owner change
        step(); i_req = 1;
        wait_gnt(0, "t3_i_own");
        step(); d_req = 1; i_rd = 1; i_addr = 16'h0000; m_busy = 4'hF;
        step(); i_addr = 16'h0001;
        step(); i_addr = 16'h0002; m_data_out = 16'hA000;
        @(negedge clk); chk("t3_word0", i_data_out, 16'hA000);
        step(); i_addr = 16'h0003; m_data_out = 16'hA001;
        step(); i_rd = 0; i_req = 0; m_data_out = 16'hA002;
        step(); m_data_out = 16'hA003;
        @(negedge clk);
        chk("t3_word3", i_data_out, 16'hA003);
        chk("t3_d_data", d_data_out, 16'h0000);
        chk("t3_d_gnt", d_gnt, 0);
        step(); m_data_out = 0;
        repeat (3) begin
            step();
            @(negedge clk); chk("t3_busy_hold", d_gnt, 0);
        end
        step(); m_busy = 0;
        wait_gnt(1, "t3_d_own");

        // 4: illegal strobe and error forwarding
        step(); d_wr = 1; d_rd = 1; d_addr = 16'h1234; d_data_in = 16'h5555;
        @(negedge clk);
        chk("t4_m_wr", m_wr, 0);
        chk("t4_m_rd", m_rd, 0);
        chk("t4_d_err", d_err, 1);
        chk("t4_d_gnt", d_gnt, 1);
        step(); d_wr = 0; d_rd = 0;
        @(negedge clk);
        chk("t4_err_clr", d_err, 0);
        chk("t4_gnt_kept", d_gnt, 1);
        step(); m_err = 1;
        @(negedge clk);
        chk("t4_merr_d", d_err, 1);
        chk("t4_merr_i", i_err, 0);
        step(); m_err = 0; d_wr = 1;
        @(negedge clk);
        chk("t4_wr", m_wr, 1);
        chk("t4_wdata", m_data_in, 16'h5555);
        step(); d_wr = 0;

        // 5: starvation yield
        step(); i_req = 1;
        repeat (63) step();
        @(negedge clk); chk("t5_no_yield", d_yield, 0);
        step();
        @(negedge clk);
        chk("t5_yield", d_yield, 1);
        chk("t5_no_revoke", d_gnt, 1);
        step();
        @(negedge clk); chk("t5_yield_held", d_yield, 1);
        step(); d_req = 0;
        @(negedge clk); chk("t5_yield_drop", d_yield, 0);
        wait_gnt(0, "t5_i_gnt");
        chk("t5_yield_off", d_yield, 0);

        // 6: async reset with reads in flight
        step(); i_rd = 1; i_addr = 16'h0080;
        step(); i_addr = 16'h0081;
        #2 rst = 0;
        #1;
        chk("t6_i_gnt", i_gnt, 0);
        chk("t6_d_gnt", d_gnt, 0);
        chk("t6_m_rd", m_rd, 0);
        chk("t6_i_busy", i_busy, 4'hF);
        chk("t6_d_busy", d_busy, 4'hF);
        step(); i_req = 0; i_rd = 0; m_data_out = 16'hDEAD;
        step(); rst = 1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_no_i_data", i_data_out, 16'h0000);
            chk("t6_no_d_data", d_data_out, 16'h0000);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
